// File: rtl/e203_ifu_pkg.sv
// e203_ifu_pkg: shared state encoding and sizing helpers for the IFU prefetch buffer.
package e203_ifu_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    // Returns at least 1 so that single-entry structures still get a usable pointer.
    function automatic int clog2(input int n);
        int r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int fb_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/e203_pfbuf_fifo.sv
// e203_pfbuf_fifo: synchronous FIFO with push/pop/clear and occupancy count.
module e203_pfbuf_fifo
    import e203_ifu_pkg::*;
#(
    parameter int W = 65,
    parameter int DEPTH = 4,
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] cnt
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rp, wp;
    logic          full, empty, do_push, do_pop;

    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            rp  <= do_pop ? inc(rp) : rp;
            wp  <= do_push ? inc(wp) : wp;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wp] <= wdata;
    end

endmodule

// File: rtl/e203_ifu_pfbuf.sv
// e203_ifu_pfbuf: sequential instruction prefetch buffer feeding the IFU from the ICB fetch port.
// Optional macro E203_PFBUF_BYPASS_EN forwards a response straight to out_* when the FIFO is empty.
module e203_ifu_pfbuf
    import e203_ifu_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int OUTS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    input  logic              halt_req,
    output logic              halt_ack,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic [PC_W-1:0]   icb_cmd_addr,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic              icb_rsp_err,
    input  logic [DATA_W-1:0] icb_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              active
);

    localparam int FB = fb_bytes(DATA_W);
    localparam int EW = PC_W + DATA_W + 1;
    localparam int OW = clog2(OUTS + 1);
    localparam int CW = clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic              err;
    } entry_t;

    state_t          state, state_nx;
    logic [PC_W-1:0] next_addr, tag;
    logic [OW-1:0]   outst, outst_nx, discard, live;
    logic [CW-1:0]   fifo_cnt;
    logic            err_stop, cmd_hs, rsp_hs, keep, push, pop, fifo_empty;
    entry_t          head, rsp_e;

    assign icb_rsp_ready = 1'b1;
    assign icb_cmd_addr  = next_addr;
    assign halt_ack      = state == ST_HALT;
    assign active        = state != ST_IDLE || outst != '0;
    assign fifo_empty    = fifo_cnt == '0;
    assign live          = outst - discard;
    assign cmd_hs        = icb_cmd_valid && icb_cmd_ready;
    // A response with nothing outstanding is a leftover from before reset.
    assign rsp_hs        = icb_rsp_valid && outst != '0;
    assign outst_nx      = outst + OW'(cmd_hs) - OW'(rsp_hs);
    assign keep          = rsp_hs && discard == '0 && !redir_valid;
    assign rsp_e         = '{pc: tag, data: icb_rsp_rdata, err: icb_rsp_err};
    assign icb_cmd_valid = state == ST_RUN && !halt_req && !err_stop && !redir_valid
                         && 32'(outst) < OUTS && 32'(fifo_cnt) + 32'(live) < DEPTH;

`ifdef E203_PFBUF_BYPASS_EN
    logic byp;
    assign byp       = fifo_empty && keep;
    assign push      = keep && !(byp && out_ready);
    assign out_valid = !fifo_empty || byp;
    assign {out_pc, out_data, out_err} = fifo_empty ? rsp_e : head;
`else
    assign push      = keep;
    assign out_valid = !fifo_empty;
    assign {out_pc, out_data, out_err} = head;
`endif

    assign pop = out_valid && out_ready && !redir_valid && !fifo_empty;

    always_comb begin
        state_nx = state;
        state_nx = (state == ST_IDLE) ? (redir_valid ? ST_RUN : ST_IDLE)
                 : (state == ST_RUN)  ? ((halt_req && outst == '0) ? ST_HALT : ST_RUN)
                 : (halt_req ? ST_HALT : ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            discard   <= '0;
            err_stop  <= 1'b0;
        end else begin
            state     <= state_nx;
            next_addr <= redir_valid ? (redir_pc & ~PC_W'(FB - 1))
                       : cmd_hs ? next_addr + PC_W'(FB) : next_addr;
            discard   <= redir_valid ? outst_nx
                       : (rsp_hs && discard != '0) ? discard - OW'(1) : discard;
            err_stop  <= redir_valid ? 1'b0 : (keep && icb_rsp_err) ? 1'b1 : err_stop;
        end
    end

    e203_pfbuf_fifo #(.W(EW), .DEPTH(DEPTH)) u_data (
        .clk   (clk),
        .rst   (rst),
        .clr   (redir_valid),
        .push  (push),
        .pop   (pop),
        .wdata (rsp_e),
        .rdata (head),
        .cnt   (fifo_cnt)
    );

    // Tag queue occupancy doubles as the outstanding-read counter.
    e203_pfbuf_fifo #(.W(PC_W), .DEPTH(OUTS)) u_tag (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (cmd_hs),
        .pop   (rsp_hs),
        .wdata (next_addr),
        .rdata (tag),
        .cnt   (outst)
    );

endmodule
